seq_squarer: RTL and testbench

SEQ_SQUARER -- requirements
Module: seq_squarer

---
 rtl/seq_squarer.sv | 120 ++++++++++++
 tb/tb_seq_squarer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_squarer.sv
// Sequential shift-and-add squarer.
// Accepts an unsigned operand in idle, runs exactly WIDTH add/shift iterations, then pulses
// done_o for one cycle while sq_o presents the exact square. sq_o only changes on the
// completion edge, so it keeps the previous result while a new square is being computed.
module seq_squarer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH:0]   sq_o
);

  // Result, accumulator and multiplicand share one width; one spare bit keeps every
  // intermediate sum from overflowing.
  localparam int unsigned RW = 2 * WIDTH + 1;
  // Counter must hold 0..WIDTH-1.
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    sq_q, sq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    acc_sum;

  // Next-state and datapath: one add/shift step per CALC cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d  = {{(WIDTH + 1){1'b0}}, x_i};
          mplier_d = x_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[RW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // The last iteration publishes its own sum directly, saving a cycle.
        if (cnt_q == LastIter) begin
          sq_d    = acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs follow the registered state, so they are Moore by construction.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sq_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sq_o   = sq_q;

`ifndef SYNTHESIS
  // A square of a WIDTH-bit value never reaches the top bit.
  sq_msb_zero_a : assert property (@(posedge clk_i) disable iff (!rst_n_i) !sq_q[RW-1]);
  // DONE always falls back to IDLE, so done_o never lasts two cycles.
  done_pulse_a : assert property (@(posedge clk_i) disable iff (!rst_n_i) done_q |=> !done_q);
  // Outputs stay consistent with the state register.
  done_busy_a : assert property (@(posedge clk_i) disable iff (!rst_n_i) done_q |-> busy_q);
`endif

endmodule

// File: tb/tb_seq_squarer.sv
// Self-checking bench for seq_squarer: expected squares are queued at acceptance and
// compared when done_o pulses.
module tb_seq_squarer;

  localparam int unsigned W = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    x;
  logic            busy;
  logic            done;
  logic [2*W:0]    sq;

  int              checks;
  int              failures;
  logic [2*W:0]    exp_q[$];

  seq_squarer #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .x_i    (x),
    .busy_o (busy),
    .done_o (done),
    .sq_o   (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand for one accepting edge and queue its square.
  task automatic accept(input logic [W-1:0] v);
    int e;
    start = 1'b1;
    x     = v;
    tick();
    start = 1'b0;
    e     = int'(v) * int'(v);
    exp_q.push_back((2*W+1)'(e));
  endtask

  // Edges until done_o is seen, or -1 if it never shows within the budget.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic test_reset();
    int n;
    logic [2*W:0] e;
    rst_n = 1'b0;
    start = 1'b1;
    x     = 8'd99;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sq !== '0) begin failures++; $display("FAIL reset_sq: got %0d expected 0", sq); end
    // First edge with reset released accepts the pending start.
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(17'd9801);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_release_accept: busy got %b expected 1", busy); end
    wait_done(n);
    checks++; if (n != 8) begin failures++; $display("FAIL reset_release_latency: got %0d expected 8", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL reset_release_sq: got %0d expected %0d", sq, e); end
    tick();
  endtask

  task automatic test_basic();
    logic [2*W:0] prev;
    logic [2*W:0] e;
    logic         held;
    int           n;
    prev = sq;
    held = 1'b1;
    n    = -1;
    accept(8'd13);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early: got %b expected 0", done); end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (sq !== prev) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL basic_sq_held: got %b expected 1", held); end
    checks++; if (n != 8) begin failures++; $display("FAIL basic_latency: got %0d expected 8", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL basic_sq: got %0d expected %0d", sq, e); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    checks++; if (sq !== 17'd169) begin failures++; $display("FAIL basic_sq_hold_idle: got %0d expected 169", sq); end
  endtask

  task automatic test_boundary();
    int n;
    logic [2*W:0] e;
    accept(8'd255);
    wait_done(n);
    checks++; if (n != 8) begin failures++; $display("FAIL max_latency: got %0d expected 8", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL max_sq: got %0d expected %0d", sq, e); end
    checks++; if (sq[2*W] !== 1'b0) begin failures++; $display("FAIL max_msb: got %b expected 0", sq[2*W]); end
    tick();
    accept(8'd0);
    wait_done(n);
    checks++; if (n != 8) begin failures++; $display("FAIL zero_latency: got %0d expected 8", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL zero_sq: got %0d expected %0d", sq, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] e;
    logic         exp_busy;
    logic         exp_done;
    start = 1'b1;
    x     = 8'd3;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i % 10 == 0) exp_q.push_back(17'd9);
      exp_busy = (i % 10 != 9);
      exp_done = (i % 10 == 8);
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, busy, exp_busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, done, exp_done); end
      if (done === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (sq !== e) begin failures++; $display("FAIL b2b_sq[%0d]: got %0d expected %0d", i, sq, e); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_x_change();
    int n;
    logic [2*W:0] e;
    accept(8'd10);
    tick();
    x = 8'd200;
    wait_done(n);
    checks++; if (n != 7) begin failures++; $display("FAIL xchg_latency: got %0d expected 7", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL xchg_sq: got %0d expected %0d", sq, e); end
    tick();
  endtask

  task automatic test_reset_abort();
    int n;
    logic seen_done;
    logic [2*W:0] e;
    accept(8'd77);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    void'(exp_q.pop_front());
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (sq !== '0) begin failures++; $display("FAIL abort_sq: got %0d expected 0", sq); end
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got %b expected 0", busy); end
    accept(8'd16);
    wait_done(n);
    checks++; if (n != 8) begin failures++; $display("FAIL abort_next_latency: got %0d expected 8", n); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (sq !== e) begin failures++; $display("FAIL abort_next_sq: got %0d expected %0d", sq, e); end
    tick();
  endtask

  task automatic test_sweep();
    int n;
    logic [2*W:0] e;
    for (int v = 0; v < 256; v++) begin
      accept(W'(v));
      wait_done(n);
      checks++; if (n != 8) begin failures++; $display("FAIL sweep_latency[%0d]: got %0d expected 8", v, n); end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      checks++; if (sq !== e) begin failures++; $display("FAIL sweep_sq[%0d]: got %0d expected %0d", v, sq, e); end
      checks++; if (isqrt(int'(sq)) != v) begin failures++; $display("FAIL sweep_sqrt[%0d]: got %0d expected %0d", v, isqrt(int'(sq)), v); end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    x        = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_x_change();
    test_reset_abort();
    test_sweep();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
